max_pool_stream: RTL and testbench
==================================

// Module: max_pool_stream
// PURPOSE
//  2x2/stride-2 signed max-pool stage between conv output and dense_layer.
//  Accepts a 26x26 raster-order conv feature map, one pixel per handshake, and pools it to 13x13 = 169 features.
//  Buffers the full pooled map, then pulses dense_start.
//  Streams the 169 features back-to-back on feature_out in the cycle-exact order dense_layer samples them.
// PARAMETERS
//  IN_DIM    26   input map width/height (must be even)
//  POOL_DIM  13   IN_DIM/2; pooled map is POOL_DIM*POOL_DIM = 169 entries
//  DATA_W    16   signed pixel/feature width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  in_valid     in   1       pixel valid
//  in_sof       in   1       qualifies in_data as pixel (0,0) of a new frame
//  in_data      in   DATA_W  signed conv pixel, raster order (row-major)
//  in_ready     out  1       1 only in S_FILL; a pixel is accepted when in_valid&&in_ready
//  dense_start  out  1       one-cycle pulse; connects to dense_layer.start
//  feature_out  out  DATA_W  signed pooled feature; connects to dense_layer.feature_in
//  streaming    out  1       high while feature_out carries valid features
//  done         out  1       one-cycle pulse after the last feature
// BEHAVIOUR
//  Reset:
//   - state=S_FILL, row/col counters=0, dense_start=0, done=0, streaming=0, feature_out=0.
//   - Buffers are not cleared; any partial frame is discarded.
//  Storage:
//   - hold reg (DATA_W)
//   - rowbuf[POOL_DIM] (DATA_W)
//   - outbuf[169] (DATA_W)
//  Pooling, per accepted pixel at (r,c); all compares are signed; ties keep either value (equal):
//   - r even, c even: hold <= pix.
//   - r even, c odd:  rowbuf[c/2] <= max(hold,pix).
//   - r odd,  c even: hold <= max(rowbuf[c/2],pix).
//   - r odd,  c odd:  outbuf[(r/2)*POOL_DIM + c/2] <= max(hold,pix).
//   - c wraps IN_DIM-1 -> 0 with r++.
//  FSM:
//   - S_FILL: accept pixels.
//     - Accepting (IN_DIM-1,IN_DIM-1) -> S_START next cycle.
//     - in_sof accepted: counters forced so this pixel is (0,0), mid-frame or not; partial data is overwritten.
//     - in_sof=0 at count 0 is accepted as (0,0).
//   - S_START (1 cycle): dense_start=1; in_ready=0 -> S_STREAM.
//   - S_STREAM (169 cycles):
//     - feature_out = outbuf[k] in cycle k+1 after the dense_start cycle, k=0..168, contiguous, no gaps.
//     - streaming=1 in exactly those 169 cycles.
//     - Then -> S_DONE.
//   - S_DONE (1 cycle): done=1, feature_out=0, streaming=0 -> S_FILL with counters=0.
//  Pixels presented while in_ready=0 are not accepted (upstream must hold).
//  Latency: last input pixel accept (cycle T) -> dense_start at T+1 -> first feature at T+2 -> last feature at T+170 -> done at T+171.
//  Back-to-back frames: next frame accepted from cycle after done.
//  Outputs are registered; no combinational path from inputs to outputs except in_ready (state-decoded only).
//  Reset asserted mid-stream: outputs drop to reset values asynchronously; dense_layer must share reset.
// TESTING
//  1. Ramp frame, pix(r,c)=r*26+c, continuous valid -> feature[i*13+j] = (2i+1)*26+2j+1.
//     - Check: feature[0]=27, feature[168]=675; dense_start exactly once; 169 contiguous streaming cycles; done at T+171.
//  2. All-negative frame, pix=-1000 except pix(1,1)=-3 and pix(25,24)=-7.
//     - Check: feature[0]=-3, feature[168]=-7, all others -1000 (signed compare).
//  3. Random frame with in_valid 50% random gaps.
//     - Check: features match golden model; no pixel accepted while in_ready=0.
//  4. Resync: send 300 pixels, then in_sof with a full ramp frame.
//     - Check: output identical to test 1; exactly one dense_start.
//  5. Reset asserted at stream cycle 80.
//     - Check: streaming/feature_out/done=0 immediately.
//     - Then send a new full frame -> correct 169 features; no stale dense_start.
//  6. Integration with dense_layer, all features=1, weights known.
//     - Check: class scores = sum(weights)+bias; dense done follows this block's done by 2 cycles.

Source files
------------

// File: rtl/max_pool_stream_if.sv
// rtl/max_pool_stream_if.sv - pixel input and pooled-feature output bundle for max_pool_stream
interface max_pool_stream_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_sof;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     dense_start;
    logic signed [DATA_W-1:0] feature_out;
    logic                     streaming;
    logic                     done;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, dense_start, feature_out, streaming, done
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, dense_start, feature_out, streaming, done
    );
endinterface

// File: rtl/max_pool_stream.sv
// rtl/max_pool_stream.sv - 2x2 stride-2 signed max-pool of a raster frame, buffered then streamed to dense_layer
module max_pool_stream #(
    parameter int IN_DIM   = 26,
    parameter int POOL_DIM = IN_DIM / 2,
    parameter int DATA_W   = 16
) (
    input logic               clk,
    input logic               reset,
    max_pool_stream_if.slave  bus
);
    localparam int N_FEAT = POOL_DIM * POOL_DIM;
    localparam int CW     = $clog2(IN_DIM);
    localparam int PW     = $clog2(POOL_DIM);
    localparam int AW     = $clog2(N_FEAT);

    typedef enum logic [1:0] {S_FILL, S_START, S_STREAM, S_DONE} state_t;

    state_t                   r_state, w_next_state;
    logic [CW-1:0]            r_row, r_col, w_row, w_col, w_next_row, w_next_col;
    logic [AW-1:0]            r_idx, w_next_idx;
    logic signed [DATA_W-1:0] r_hold;
    logic signed [DATA_W-1:0] r_rowbuf [POOL_DIM];
    logic signed [DATA_W-1:0] r_outbuf [N_FEAT];
    logic                     r_dense_start, r_streaming, r_done;
    logic signed [DATA_W-1:0] r_feature, w_feature;
    logic                     w_accept, w_last_pix;
    logic [PW-1:0]            w_pcol;
    logic [AW-1:0]            w_oaddr;
    logic signed [DATA_W-1:0] w_pix;

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign bus.in_ready    = (r_state == S_FILL);
    assign bus.dense_start = r_dense_start;
    assign bus.feature_out = r_feature;
    assign bus.streaming   = r_streaming;
    assign bus.done        = r_done;

    // A start-of-frame pixel is always treated as (0,0), discarding any partial frame
    assign w_accept   = bus.in_valid && (r_state == S_FILL);
    assign w_row      = bus.in_sof ? '0 : r_row;
    assign w_col      = bus.in_sof ? '0 : r_col;
    assign w_pix      = bus.in_data;
    assign w_last_pix = w_accept && (w_row == CW'(IN_DIM - 1)) && (w_col == CW'(IN_DIM - 1));
    assign w_pcol     = PW'(w_col >> 1);
    assign w_oaddr    = AW'(w_row >> 1) * AW'(POOL_DIM) + AW'(w_col >> 1);

    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_col   = r_col;
        w_next_idx   = r_idx;
        w_feature    = '0;
        unique case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (w_col == CW'(IN_DIM - 1)) begin
                        w_next_col = '0;
                        w_next_row = w_row + CW'(1);
                    end else begin
                        w_next_col = w_col + CW'(1);
                        w_next_row = w_row;
                    end
                    if (w_last_pix) begin
                        w_next_state = S_START;
                        w_next_row   = '0;
                        w_next_col   = '0;
                    end
                end
            end
            S_START: begin
                w_next_state = S_STREAM;
                w_next_idx   = '0;
                w_feature    = r_outbuf[0];
            end
            S_STREAM: begin
                // Feature register is loaded one cycle ahead so feature k appears in stream cycle k
                if (r_idx == AW'(N_FEAT - 1)) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_idx = r_idx + AW'(1);
                    w_feature  = r_outbuf[w_next_idx];
                end
            end
            S_DONE: begin
                w_next_state = S_FILL;
                w_next_row   = '0;
                w_next_col   = '0;
            end
            default: w_next_state = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_row         <= '0;
            r_col         <= '0;
            r_idx         <= '0;
            r_dense_start <= 1'b0;
            r_streaming   <= 1'b0;
            r_done        <= 1'b0;
            r_feature     <= '0;
        end else begin
            r_state       <= w_next_state;
            r_row         <= w_next_row;
            r_col         <= w_next_col;
            r_idx         <= w_next_idx;
            r_dense_start <= (w_next_state == S_START);
            r_streaming   <= (w_next_state == S_STREAM);
            r_done        <= (w_next_state == S_DONE);
            r_feature     <= w_feature;
        end
    end

    // Even rows park horizontal pair maxima in rowbuf; odd rows fold them into the final 2x2 max
    always_ff @(posedge clk) begin
        if (w_accept) begin
            unique case ({w_row[0], w_col[0]})
                2'b00: r_hold           <= w_pix;
                2'b01: r_rowbuf[w_pcol] <= smax(r_hold, w_pix);
                2'b10: r_hold           <= smax(r_rowbuf[w_pcol], w_pix);
                2'b11: r_outbuf[w_oaddr] <= smax(r_hold, w_pix);
            endcase
        end
    end
endmodule

// File: tb/tb_max_pool_stream.sv
// tb/tb_max_pool_stream.sv - self-checking bench for max_pool_stream against a direct 2x2 max reference
module tb_max_pool_stream;
    localparam int IN_DIM = 26;
    localparam int PD     = 13;
    localparam int NF     = PD * PD;
    localparam int NP     = IN_DIM * IN_DIM;
    localparam int DW     = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    max_pool_stream_if #(.DATA_W(DW)) bus ();

    max_pool_stream #(.IN_DIM(IN_DIM), .POOL_DIM(PD), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int gap_pct  = 0;
    int n_start, start_cyc, n_done, first_acc, last_acc;
    int scyc[$];
    int dcyc[$];
    logic signed [DW-1:0] feats[$];
    logic signed [DW-1:0] frame [NP];
    logic signed [DW-1:0] exp_f [NF];
    logic signed [DW-1:0] exp_a [NF];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dense_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (bus.streaming) begin
            feats.push_back(bus.feature_out);
            scyc.push_back(cyc);
        end
        if (bus.done) begin
            n_done++;
            dcyc.push_back(cyc);
        end
    end

    // Reference: each feature is the signed max of its 2x2 input window
    function automatic void build_exp();
        for (int i = 0; i < PD; i++) begin
            for (int j = 0; j < PD; j++) begin
                logic signed [DW-1:0] m;
                m = frame[(2*i)*IN_DIM + 2*j];
                if (frame[(2*i)*IN_DIM + 2*j + 1] > m) m = frame[(2*i)*IN_DIM + 2*j + 1];
                if (frame[(2*i+1)*IN_DIM + 2*j] > m) m = frame[(2*i+1)*IN_DIM + 2*j];
                if (frame[(2*i+1)*IN_DIM + 2*j + 1] > m) m = frame[(2*i+1)*IN_DIM + 2*j + 1];
                exp_f[i*PD + j] = m;
            end
        end
    endfunction

    task automatic clear_mon();
        feats.delete();
        scyc.delete();
        dcyc.delete();
        n_start   = 0;
        n_done    = 0;
        start_cyc = -1;
    endtask

    task automatic push(input logic signed [DW-1:0] d, input logic sof);
        int waits = 0;
        if ($urandom_range(99) < gap_pct) repeat ($urandom_range(3, 1)) @(negedge clk);
        forever begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_sof   = sof;
            if (bus.in_ready) break;
            waits++;
            if (waits > 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL push_timeout in_ready stayed 0 for %0d cycles, required 1", waits);
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (first_acc < 0) first_acc = cyc - 1;
        last_acc     = cyc - 1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic sof);
        first_acc = -1;
        for (int p = 0; p < NP; p++) push(frame[p], sof && (p == 0));
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_done < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout done pulses=%0d required %0d", n_done, target);
        end
    endtask

    task automatic fill_ramp();
        for (int p = 0; p < NP; p++) frame[p] = DW'(p);
    endtask

    task automatic fill_random();
        for (int p = 0; p < NP; p++) frame[p] = DW'($urandom);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.dense_start !== 1'b0) begin n_errors++; $display("FAIL reset_dense_start got %b exp 0", bus.dense_start); end
        n_checks++; if (bus.streaming !== 1'b0) begin n_errors++; $display("FAIL reset_streaming got %b exp 0", bus.streaming); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_checks++; if (bus.feature_out !== '0) begin n_errors++; $display("FAIL reset_feature got %0d exp 0", bus.feature_out); end
        reset = 1'b0;
    endtask

    task automatic test_ramp();
        fill_ramp();
        build_exp();
        clear_mon();
        gap_pct = 0;
        send_frame(1'b1);
        wait_done(1);
        n_checks++; if (feats.size() != NF) begin n_errors++; $display("FAIL ramp_count got %0d exp %0d", feats.size(), NF); end
        n_checks++; if (feats[0] !== 16'sd27) begin n_errors++; $display("FAIL ramp_first got %0d exp 27", feats[0]); end
        n_checks++; if (feats[NF-1] !== 16'sd675) begin n_errors++; $display("FAIL ramp_last got %0d exp 675", feats[NF-1]); end
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (feats[k] !== exp_f[k]) begin n_errors++; $display("FAIL ramp_feat[%0d] got %0d exp %0d", k, feats[k], exp_f[k]); end
        end
        n_checks++; if (n_start != 1) begin n_errors++; $display("FAIL ramp_start_count got %0d exp 1", n_start); end
        n_checks++; if (start_cyc != last_acc + 1) begin n_errors++; $display("FAIL ramp_start_cycle got %0d exp %0d", start_cyc, last_acc + 1); end
        n_checks++; if (scyc.size() != NF || scyc[0] != last_acc + 2 || scyc[NF-1] != last_acc + 170) begin
            n_errors++; $display("FAIL ramp_stream_window got first %0d last %0d exp %0d..%0d", scyc[0], scyc[scyc.size()-1], last_acc + 2, last_acc + 170);
        end
        n_checks++; if (dcyc.size() != 1 || dcyc[0] != last_acc + 171) begin n_errors++; $display("FAIL ramp_done_cycle got %0d exp %0d", dcyc[0], last_acc + 171); end
    endtask

    task automatic test_negative();
        for (int p = 0; p < NP; p++) frame[p] = -16'sd1000;
        frame[1*IN_DIM + 1]  = -16'sd3;
        frame[25*IN_DIM + 24] = -16'sd7;
        clear_mon();
        gap_pct = 0;
        send_frame(1'b0);
        wait_done(1);
        n_checks++; if (feats.size() != NF) begin n_errors++; $display("FAIL neg_count got %0d exp %0d", feats.size(), NF); end
        for (int k = 0; k < NF; k++) begin
            logic signed [DW-1:0] e;
            e = (k == 0) ? -16'sd3 : (k == NF - 1) ? -16'sd7 : -16'sd1000;
            n_checks++;
            if (feats[k] !== e) begin n_errors++; $display("FAIL neg_feat[%0d] got %0d exp %0d", k, feats[k], e); end
        end
    endtask

    task automatic test_random_gaps();
        fill_random();
        build_exp();
        clear_mon();
        gap_pct = 50;
        send_frame(1'b1);
        gap_pct = 0;
        wait_done(1);
        n_checks++; if (feats.size() != NF) begin n_errors++; $display("FAIL gaps_count got %0d exp %0d", feats.size(), NF); end
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (feats[k] !== exp_f[k]) begin n_errors++; $display("FAIL gaps_feat[%0d] got %0d exp %0d", k, feats[k], exp_f[k]); end
        end
        n_checks++; if (n_start != 1) begin n_errors++; $display("FAIL gaps_start_count got %0d exp 1", n_start); end
        n_checks++; if (dcyc.size() != 1 || dcyc[0] != last_acc + 171) begin n_errors++; $display("FAIL gaps_done_cycle got %0d exp %0d", dcyc[0], last_acc + 171); end
    endtask

    task automatic test_resync();
        clear_mon();
        gap_pct = 0;
        for (int p = 0; p < 300; p++) push(DW'($urandom), 1'b0);
        fill_ramp();
        build_exp();
        send_frame(1'b1);
        wait_done(1);
        n_checks++; if (feats.size() != NF) begin n_errors++; $display("FAIL resync_count got %0d exp %0d", feats.size(), NF); end
        n_checks++; if (feats[0] !== 16'sd27) begin n_errors++; $display("FAIL resync_first got %0d exp 27", feats[0]); end
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (feats[k] !== exp_f[k]) begin n_errors++; $display("FAIL resync_feat[%0d] got %0d exp %0d", k, feats[k], exp_f[k]); end
        end
        n_checks++; if (n_start != 1) begin n_errors++; $display("FAIL resync_start_count got %0d exp 1", n_start); end
    endtask

    task automatic test_reset_midstream();
        int t = 0;
        fill_random();
        clear_mon();
        gap_pct = 0;
        send_frame(1'b1);
        while (feats.size() < 80 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_checks++; if (feats.size() < 80) begin n_errors++; $display("FAIL rst_mid_reach got %0d features exp 80", feats.size()); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.streaming !== 1'b0) begin n_errors++; $display("FAIL rst_mid_streaming got %b exp 0", bus.streaming); end
        n_checks++; if (bus.feature_out !== '0) begin n_errors++; $display("FAIL rst_mid_feature got %0d exp 0", bus.feature_out); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL rst_mid_done got %b exp 0", bus.done); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_in_ready got %b exp 1", bus.in_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        repeat (20) @(negedge clk);
        n_checks++; if (n_start != 0 || n_done != 0 || feats.size() != 0) begin
            n_errors++; $display("FAIL rst_stale got start=%0d done=%0d feats=%0d exp 0/0/0", n_start, n_done, feats.size());
        end
        fill_random();
        build_exp();
        send_frame(1'b0);
        wait_done(1);
        n_checks++; if (feats.size() != NF) begin n_errors++; $display("FAIL rst_new_count got %0d exp %0d", feats.size(), NF); end
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (feats[k] !== exp_f[k]) begin n_errors++; $display("FAIL rst_new_feat[%0d] got %0d exp %0d", k, feats[k], exp_f[k]); end
        end
        n_checks++; if (n_start != 1) begin n_errors++; $display("FAIL rst_new_start_count got %0d exp 1", n_start); end
    endtask

    task automatic test_back_to_back();
        int acc_b_first, acc_b_last;
        clear_mon();
        gap_pct = 0;
        fill_random();
        build_exp();
        exp_a = exp_f;
        send_frame(1'b1);
        fill_random();
        build_exp();
        send_frame(1'b0);
        acc_b_first = first_acc;
        acc_b_last  = last_acc;
        wait_done(2);
        n_checks++; if (feats.size() != 2 * NF) begin n_errors++; $display("FAIL b2b_count got %0d exp %0d", feats.size(), 2 * NF); end
        for (int k = 0; k < NF; k++) begin
            n_checks++;
            if (feats[k] !== exp_a[k]) begin n_errors++; $display("FAIL b2b_a_feat[%0d] got %0d exp %0d", k, feats[k], exp_a[k]); end
            n_checks++;
            if (feats[NF + k] !== exp_f[k]) begin n_errors++; $display("FAIL b2b_b_feat[%0d] got %0d exp %0d", k, feats[NF + k], exp_f[k]); end
        end
        n_checks++; if (n_start != 2) begin n_errors++; $display("FAIL b2b_start_count got %0d exp 2", n_start); end
        n_checks++; if (dcyc.size() != 2 || acc_b_first != dcyc[0] + 1) begin
            n_errors++; $display("FAIL b2b_first_accept got %0d exp %0d", acc_b_first, dcyc[0] + 1);
        end
        n_checks++; if (dcyc.size() != 2 || dcyc[1] != acc_b_last + 171) begin
            n_errors++; $display("FAIL b2b_done_cycle got %0d exp %0d", dcyc[dcyc.size()-1], acc_b_last + 171);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_random_gaps();
        test_resync();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
